// File: rtl/rsa_key_if.sv
// Handshake and key-result bundle between an RSA key sequencer and its user.
interface rsa_key_if #(
    parameter int M = 5
);
    logic             start;
    logic [M-1:0]     prime_in;
    logic             prime_valid;
    logic             prime_ready;
    logic [M-1:0]     key_p;
    logic [M-1:0]     key_q;
    logic [M-1:0]     key_e;
    logic [2*M-1:0]   key_n;
    logic [2*M-1:0]   key_phi;
    logic             busy;
    logic             done;
    logic             fail;

    modport master (
        output start, prime_in, prime_valid,
        input  prime_ready, key_p, key_q, key_e, key_n, key_phi, busy, done, fail
    );

    modport slave (
        input  start, prime_in, prime_valid,
        output prime_ready, key_p, key_q, key_e, key_n, key_phi, busy, done, fail
    );
endinterface

// File: rtl/rsa_key_sequencer.sv
// Collects p, q, e from a prime source, checks gcd(e, phi) == 1, publishes the key set.
// Optional GET-state watchdog enabled by defining RSA_KEYSEQ_TIMEOUT_EN.
module rsa_key_sequencer #(
    parameter int M         = 5,
    parameter int MAX_TRIES = 15
) (
    input logic   clk,
    input logic   rst_n,
    rsa_key_if.slave bus
);
    localparam int W2 = 2 * M;
    localparam int RW = $clog2(MAX_TRIES + 2);

    typedef enum logic [2:0] {
        StIdle,
        StGetP,
        StGetQ,
        StGetE,
        StCalc,
        StGcd,
        StDone,
        StFail
    } state_e;

    state_e          state_q;
    logic [M-1:0]    p_q, q_q, e_q;
    logic [W2-1:0]   n_q, phi_q, a_q, b_q;
    logic [RW-1:0]   retry_q;
    logic [M-1:0]    key_p_q, key_q_q, key_e_q;
    logic [W2-1:0]   key_n_q, key_phi_q;

    logic in_get, xfer, cand_small, tries_left;

    assign in_get     = (state_q == StGetP) || (state_q == StGetQ) || (state_q == StGetE);
    assign xfer       = bus.prime_valid && in_get;
    assign cand_small = bus.prime_in < M'(3);
    // One more reject is allowed only while the count is still below the limit.
    assign tries_left = retry_q != RW'(MAX_TRIES);

    assign bus.prime_ready = in_get;
    assign bus.busy        = state_q != StIdle;
    assign bus.done        = state_q == StDone;
    assign bus.fail        = state_q == StFail;
    assign bus.key_p       = key_p_q;
    assign bus.key_q       = key_q_q;
    assign bus.key_e       = key_e_q;
    assign bus.key_n       = key_n_q;
    assign bus.key_phi     = key_phi_q;

`ifdef RSA_KEYSEQ_TIMEOUT_EN
    logic [5:0] wd_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            p_q       <= '0;
            q_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            phi_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            retry_q   <= '0;
            key_p_q   <= '0;
            key_q_q   <= '0;
            key_e_q   <= '0;
            key_n_q   <= '0;
            key_phi_q <= '0;
`ifdef RSA_KEYSEQ_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StGetP;
                        retry_q <= '0;
                    end
                end
                StGetP: begin
                    if (xfer) begin
                        if (cand_small) begin
                            if (tries_left) retry_q <= retry_q + RW'(1);
                            else            state_q <= StFail;
                        end else begin
                            p_q     <= bus.prime_in;
                            state_q <= StGetQ;
                        end
                    end
                end
                StGetQ: begin
                    if (xfer) begin
                        if (cand_small || (bus.prime_in == p_q)) begin
                            if (tries_left) retry_q <= retry_q + RW'(1);
                            else            state_q <= StFail;
                        end else begin
                            q_q     <= bus.prime_in;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    n_q     <= W2'(p_q) * W2'(q_q);
                    phi_q   <= (W2'(p_q) - W2'(1)) * (W2'(q_q) - W2'(1));
                    state_q <= StGetE;
                end
                StGetE: begin
                    if (xfer) begin
                        if (cand_small || (bus.prime_in == p_q) || (bus.prime_in == q_q)) begin
                            if (tries_left) retry_q <= retry_q + RW'(1);
                            else            state_q <= StFail;
                        end else begin
                            e_q     <= bus.prime_in;
                            a_q     <= phi_q;
                            b_q     <= W2'(bus.prime_in);
                            state_q <= StGcd;
                        end
                    end
                end
                StGcd: begin
                    if (b_q != '0) begin
                        a_q <= b_q;
                        b_q <= a_q % b_q;
                    end else if (a_q == W2'(1)) begin
                        // Keys only change here, so an aborted run never leaks a partial set.
                        key_p_q   <= p_q;
                        key_q_q   <= q_q;
                        key_e_q   <= e_q;
                        key_n_q   <= n_q;
                        key_phi_q <= phi_q;
                        state_q   <= StDone;
                    end else if (tries_left) begin
                        retry_q <= retry_q + RW'(1);
                        state_q <= StGetE;
                    end else begin
                        state_q <= StFail;
                    end
                end
                StDone:  state_q <= StIdle;
                StFail:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

`ifdef RSA_KEYSEQ_TIMEOUT_EN
            // Watchdog reaches 63 on the 63rd idle GET cycle; that edge goes to FAIL.
            if (in_get && !xfer) begin
                if (wd_q == 6'd62) begin
                    wd_q    <= '0;
                    state_q <= StFail;
                end else begin
                    wd_q <= wd_q + 6'd1;
                end
            end else begin
                wd_q <= '0;
            end
`endif
        end
    end
endmodule

// File: doc/rsa_key_sequencer.md
RSA_KEY_SEQUENCER -- requirements
Module: rsa_key_sequencer

Interface
REQ-001 The block SHALL have parameter M, default 5, meaning width in bits of each candidate prime.
REQ-002 The block SHALL have parameter MAX_TRIES, default 15, meaning the number of rejected candidates allowed per key attempt before failing.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a request for a new key set, sampled only in IDLE.
REQ-006 The block SHALL have port prime_in, input, M, the candidate prime from the prime generator.
REQ-007 The block SHALL have port prime_valid, input, 1, meaning prime_in holds a candidate.
REQ-008 The block SHALL have port prime_ready, output, 1, meaning the sequencer accepts prime_in this cycle.
REQ-009 The block SHALL have ports key_p, key_q and key_e, each output, M, holding the accepted p, q and e.
REQ-010 The block SHALL have ports key_n and key_phi, each output, 2M, holding p*q and (p-1)*(q-1).
REQ-011 The block SHALL have ports busy, done and fail, each output, 1, meaning FSM not IDLE, one-cycle success pulse, and one-cycle failure pulse.

Function
REQ-012 The FSM SHALL have states IDLE, GET_P, GET_Q, GET_E, CALC, GCD, DONE and FAIL.
REQ-013 A transfer SHALL occur only on a cycle with prime_valid=1 and prime_ready=1; prime_ready SHALL be 1 exactly in GET_P, GET_Q and GET_E.
REQ-014 IDLE with start=1 SHALL go to GET_P next cycle and clear the retry counter; start outside IDLE SHALL be ignored.
REQ-015 In GET_P, a transfer with prime_in>=3 SHALL load working p and go to GET_Q; prime_in<3 SHALL be discarded as a reject.
REQ-016 In GET_Q, a transfer with prime_in==p or prime_in<3 SHALL be discarded as a reject; otherwise q is loaded and the FSM goes to CALC.
REQ-017 CALC SHALL last one cycle, computing n=p*q and phi=(p-1)*(q-1) at full 2M width with no truncation, then go to GET_E.
REQ-018 In GET_E, a transfer with prime_in equal to p or q, or less than 3, SHALL be a reject; otherwise e is loaded, a<=phi, b<=e zero-extended, and the FSM goes to GCD.
REQ-019 GCD SHALL perform one Euclid step per cycle (a<=b, b<=a mod b) while b!=0; when b==0, a==1 SHALL go to DONE, and any other value SHALL count a reject and return to GET_E.
REQ-020 Each reject SHALL increment the retry counter; when a reject would make the count exceed MAX_TRIES, the FSM SHALL go to FAIL instead.
REQ-021 On entry to DONE, key_p, key_q, key_e, key_n and key_phi SHALL update together from the working registers; they SHALL otherwise hold their last value, including through FAIL.
REQ-022 DONE and FAIL SHALL each last one cycle, assert done or fail respectively for that cycle, and return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE; done and fail SHALL never be asserted together.

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-GCD or mid-handshake, SHALL immediately force IDLE, set all outputs and working registers to 0 and clear the retry counter; no partial key SHALL reach the key_* outputs.
REQ-025 The first transition after rst_n deasserts SHALL occur on a rising clk edge with start sampled in IDLE.

Configuration
REQ-026 With macro RSA_KEYSEQ_TIMEOUT_EN defined, a 6-bit watchdog SHALL count consecutive GET_* cycles without a transfer; on reaching 63, the FSM SHALL go to FAIL, and each transfer or exit from the GET states SHALL clear the watchdog.
REQ-027 Without RSA_KEYSEQ_TIMEOUT_EN, no watchdog logic SHALL exist, and the sequencer SHALL wait in GET_* indefinitely.

Verification
REQ-028 Feed 3,5,7 with valid held high after start: SHALL produce key_p=3, key_q=5, key_e=7, key_n=15, key_phi=8, and a one-cycle done pulse.
REQ-029 Feed 5,5,7,11: the second 5 SHALL be rejected, giving key_p=5, key_q=7, key_n=35, key_phi=24, and key_e=11 (retry count 1).
REQ-030 Feed 5,7,3,11: e=3 SHALL fail GCD (gcd(24,3)=3) and return to GET_E, then key_e=11 and done SHALL follow.
REQ-031 After 5,7, feed sixteen consecutive 3s with MAX_TRIES=15: fail SHALL pulse once, done SHALL stay 0, and key_* SHALL keep their prior values.
REQ-032 Pull rst_n low during GCD: all outputs SHALL be 0 immediately and busy=0; the next start SHALL run a clean sequence.
REQ-033 With RSA_KEYSEQ_TIMEOUT_EN defined, start with prime_valid held at 0: fail SHALL pulse 63 cycles after entering GET_P.
